soc_video_top: RTL and testbench

FPGA top-level for the DE-nano class board. It drives status LEDs from buttons, switches and a heartbeat, and generates a parameterizable VGA-style video stream (pixel clock, HS, VS, BLANK, 24-bit RGB) carrying a grid test pattern. The video outputs feed the board video DAC, or the screen model in simulation. The whole block runs on a single 50 MHz clock.

---
 rtl/soc_video_top.sv | 135 +++++++++++++
 tb/tb_soc_video_top.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/soc_video_top.sv
// DE-nano class FPGA top: status LEDs plus a VGA-style grid test pattern.
// Ports: FPGA_CLK1_50/sys_rst, KEY/SW in, LED out, video_CLK/HS/VS/BLANK/RGB out.
module soc_video_top #(
  parameter int HDISP     = 800,
  parameter int VDISP     = 480,
  parameter int HFP       = 40,
  parameter int HPULSE    = 48,
  parameter int HBP       = 40,
  parameter int VFP       = 13,
  parameter int VPULSE    = 3,
  parameter int VBP       = 29,
  parameter int CLK_FREQ  = 50000000,
  parameter int FRAME_DIV = 30
) (
  input  logic        FPGA_CLK1_50,
  input  logic        sys_rst,
  input  logic [1:0]  KEY,
  input  logic [3:0]  SW,
  output logic [7:0]  LED,
  output logic        video_CLK,
  output logic        video_HS,
  output logic        video_VS,
  output logic        video_BLANK,
  output logic [23:0] video_RGB
);

  localparam int HTOT = HDISP + HFP + HPULSE + HBP;
  localparam int VTOT = VDISP + VFP + VPULSE + VBP;
  localparam int HW   = $clog2(HTOT);
  localparam int VW   = $clog2(VTOT);
  localparam int HB_N = (CLK_FREQ / 2 > 1) ? CLK_FREQ / 2 : 2;
  localparam int HB_W = $clog2(HB_N);
  localparam int FD_N = (FRAME_DIV > 1) ? FRAME_DIV : 2;
  localparam int FD_W = $clog2(FD_N);

  localparam logic [HW-1:0]   H_LAST  = HW'(HTOT - 1);
  localparam logic [VW-1:0]   V_LAST  = VW'(VTOT - 1);
  localparam logic [HB_W-1:0] HB_LAST = HB_W'(HB_N - 1);
  localparam logic [FD_W-1:0] FD_LAST = FD_W'(FRAME_DIV - 1);

  logic [HW-1:0]   h;
  logic [VW-1:0]   v;
  logic [HB_W-1:0] hb_cnt;
  logic [FD_W-1:0] fr_cnt;
  logic            led_hb;
  logic            led_fr;
  logic [1:0]      led_key;
  logic [3:0]      led_sw;

  logic pix_en;
  logic h_last;
  logic v_last;
  logic blank_n;
  logic hs_n;
  logic vs_n;
  logic grid_n;

  // Video state moves on the edge where video_CLK falls, so the
  // outputs are settled when the DAC samples on its rising edge.
  assign pix_en = video_CLK;
  assign h_last = (h == H_LAST);
  assign v_last = (v == V_LAST);

  always_comb begin
    blank_n = (int'(h) < HDISP) && (int'(v) < VDISP);
    hs_n    = !((int'(h) >= HDISP + HFP) &&
                (int'(h) <  HDISP + HFP + HPULSE));
    vs_n    = !((int'(v) >= VDISP + VFP) &&
                (int'(v) <  VDISP + VFP + VPULSE));
    grid_n  = ((int'(h) % 16) == 0) || ((int'(v) % 16) == 0);
  end

  always_ff @(posedge FPGA_CLK1_50 or posedge sys_rst) begin
    if (sys_rst) begin
      video_CLK   <= 1'b0;
      h           <= '0;
      v           <= '0;
      video_HS    <= 1'b1;
      video_VS    <= 1'b1;
      video_BLANK <= 1'b0;
      video_RGB   <= '0;
    end else begin
      video_CLK <= ~video_CLK;
      if (pix_en) begin
        h <= h_last ? '0 : h + 1'b1;
        if (h_last) begin
          v <= v_last ? '0 : v + 1'b1;
        end
        video_HS    <= hs_n;
        video_VS    <= vs_n;
        video_BLANK <= blank_n;
        video_RGB   <= (blank_n && grid_n) ? 24'hFFFFFF : 24'h000000;
      end
    end
  end

  always_ff @(posedge FPGA_CLK1_50 or posedge sys_rst) begin
    if (sys_rst) begin
      hb_cnt <= '0;
      led_hb <= 1'b0;
    end else if (hb_cnt == HB_LAST) begin
      hb_cnt <= '0;
      led_hb <= ~led_hb;
    end else begin
      hb_cnt <= hb_cnt + 1'b1;
    end
  end

  always_ff @(posedge FPGA_CLK1_50 or posedge sys_rst) begin
    if (sys_rst) begin
      fr_cnt <= '0;
      led_fr <= 1'b0;
    end else if (pix_en && h_last && v_last) begin
      if (fr_cnt == FD_LAST) begin
        fr_cnt <= '0;
        led_fr <= ~led_fr;
      end else begin
        fr_cnt <= fr_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge FPGA_CLK1_50 or posedge sys_rst) begin
    if (sys_rst) begin
      led_key <= '0;
      led_sw  <= '0;
    end else begin
      led_key <= ~KEY;
      led_sw  <= SW;
    end
  end

  assign LED = {led_sw, led_key, led_fr, led_hb};

endmodule

// File: tb/tb_soc_video_top.sv
// Scoreboard bench for soc_video_top with a reduced video geometry.
// Checks reset, pixel stream, sync timing, LEDs and mid-frame reset.
module tb_soc_video_top;

  localparam int HD = 40;
  localparam int VD = 36;
  localparam int HF = 4;
  localparam int HP = 6;
  localparam int HB = 6;
  localparam int VF = 2;
  localparam int VP = 3;
  localparam int VB = 3;
  localparam int CF = 100;
  localparam int FD = 2;
  localparam int HT = HD + HF + HP + HB;
  localparam int VT = VD + VF + VP + VB;
  localparam int FP = HT * VT;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        blank;
    logic [23:0] rgb;
  } pix_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  key = 2'b11;
  logic [3:0]  sw = 4'b0000;
  logic [7:0]  led;
  logic        vclk;
  logic        hs;
  logic        vs;
  logic        blank;
  logic [23:0] rgb;

  int total = 0;
  int bad = 0;

  pix_t       pq[$];
  logic [5:0] lq[$];

  always #10 clk = ~clk;

  soc_video_top #(
    .HDISP(HD), .VDISP(VD), .HFP(HF), .HPULSE(HP), .HBP(HB),
    .VFP(VF), .VPULSE(VP), .VBP(VB),
    .CLK_FREQ(CF), .FRAME_DIV(FD)
  ) dut (
    .FPGA_CLK1_50(clk),
    .sys_rst(rst),
    .KEY(key),
    .SW(sw),
    .LED(led),
    .video_CLK(vclk),
    .video_HS(hs),
    .video_VS(vs),
    .video_BLANK(blank),
    .video_RGB(rgb)
  );

  function automatic pix_t exp_pix(int k);
    pix_t p;
    int   h;
    int   v;
    h = k % HT;
    v = (k / HT) % VT;
    p.blank = (h < HD) && (v < VD);
    p.hs = !((h >= HD + HF) && (h < HD + HF + HP));
    p.vs = !((v >= VD + VF) && (v < VD + VF + VP));
    p.rgb = (p.blank && ((h % 16 == 0) || (v % 16 == 0)))
            ? 24'hFFFFFF : 24'h000000;
    return p;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rst_chk(string tag);
    chk({tag, "_led"}, led, 8'h00);
    chk({tag, "_vclk"}, vclk, 1'b0);
    chk({tag, "_hs"}, hs, 1'b1);
    chk({tag, "_vs"}, vs, 1'b1);
    chk({tag, "_blank"}, blank, 1'b0);
    chk({tag, "_rgb"}, rgb, 24'h0);
  endtask

  // Starts right after reset release at a falling clock edge;
  // n counts rising edges since release.
  task automatic run(int cycles);
    int         n;
    pix_t       p;
    logic [5:0] hi;
    logic       l0;
    logic       l1;
    n = 0;
    pq.delete();
    lq.delete();
    lq.push_back({sw, ~key});
    for (int c = 1; c <= cycles; c++) begin
      @(negedge clk);
      n++;
      chk("lq_avail", lq.size() > 0, 1'b1);
      hi = (lq.size() > 0) ? lq.pop_front() : 6'h00;
      l0 = ((n / (CF / 2)) % 2) == 1;
      l1 = (((n / 2) / FP / FD) % 2) == 1;
      chk("led", led, {hi, l1, l0});
      chk("vclk", vclk, n % 2 == 1);
      if (n % 2 == 0) begin
        pq.push_back(exp_pix(n / 2 - 1));
      end else if (n >= 3) begin
        chk("pq_avail", pq.size() > 0, 1'b1);
        if (pq.size() > 0) begin
          p = pq.pop_front();
          chk("hs", hs, p.hs);
          chk("vs", vs, p.vs);
          chk("blank", blank, p.blank);
          chk("rgb", rgb, p.rgb);
        end
      end
      if (c == 20) begin
        sw = 4'b1010;
        key = 2'b01;
      end else if (c % 37 == 0) begin
        sw = 4'($urandom);
        key = 2'($urandom);
      end
      lq.push_back({sw, ~key});
    end
  endtask

  initial begin
    #60;
    rst_chk("rst0");
    repeat (7) @(negedge clk);
    rst = 1'b0;
    run(2 * FD * FP + 600);

    #3;
    rst = 1'b1;
    #1;
    rst_chk("rst_async");
    repeat (3) begin
      @(negedge clk);
      rst_chk("rst_hold");
    end
    rst = 1'b0;
    run(400);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
